// File: rtl/ctrl_pkg.sv
// Shared types for the multicycle control unit:
// state encodings, opcodes, mux encodings, control bundle.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_ADDI  = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_SHI  = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic state_e decode_op(logic [5:0] op);
    state_e s;
    unique case (op)
      OP_RTYPE:     s = S_R_EXEC;
      OP_LW, OP_SW: s = S_MEM_ADDR;
      OP_BEQ:       s = S_BRANCH;
      OP_J:         s = S_JUMP;
      OP_ADDI:      s = S_ADDI_EXEC;
      default:      s = S_TRAP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational map from control state (and memory
// readiness) to datapath enables and mux selects.
module ctrl_output_decode
  import ctrl_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_rdy_i,
  input  logic   kill_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    if (!kill_i) begin
      unique case (state_i)
        S_FETCH: begin
          ctrl_o.mem_read  = 1'b1;
          ctrl_o.alu_src_b = SRCB_FOUR;
          ctrl_o.alu_op    = ALU_ADD;
          ctrl_o.pc_source = PCS_ALU;
          ctrl_o.ir_write  = mem_rdy_i;
          ctrl_o.pc_write  = mem_rdy_i;
        end
        S_DECODE: begin
          ctrl_o.alu_src_b = SRCB_SHI;
          ctrl_o.alu_op    = ALU_ADD;
        end
        S_MEM_ADDR: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = SRCB_IMM;
          ctrl_o.alu_op    = ALU_ADD;
        end
        S_MEM_READ: begin
          ctrl_o.mem_read = 1'b1;
          ctrl_o.i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.mem_to_reg = 1'b1;
        end
        S_MEM_WRITE: begin
          ctrl_o.mem_write = 1'b1;
          ctrl_o.i_or_d    = 1'b1;
        end
        S_R_EXEC: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = SRCB_REG;
          ctrl_o.alu_op    = ALU_FUNCT;
        end
        S_R_WB: begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          ctrl_o.alu_src_a     = 1'b1;
          ctrl_o.alu_src_b     = SRCB_REG;
          ctrl_o.alu_op        = ALU_SUB;
          ctrl_o.pc_write_cond = 1'b1;
          ctrl_o.pc_source     = PCS_ALUOUT;
        end
        S_JUMP: begin
          ctrl_o.pc_write  = 1'b1;
          ctrl_o.pc_source = PCS_JUMP;
        end
        S_ADDI_EXEC: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = SRCB_IMM;
          ctrl_o.alu_op    = ALU_ADDI;
        end
        S_ADDI_WB: begin
          ctrl_o.reg_write = 1'b1;
        end
        default: ctrl_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS-subset control unit: state register,
// next-state logic; PERF_COUNTERS_EN adds cycle/retire counters.
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter logic MEM_WAIT_EN_DEFAULT = 1'b1,
  parameter int   OPCODE_W            = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic                illegal,
  output logic [3:0]          state_out
`ifdef PERF_COUNTERS_EN
  ,
  output logic [31:0]         cycle_count,
  output logic [31:0]         retired_count
`endif
);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q;
  logic                illegal_q;
  logic                rdy;
  ctrl_t               ctrl;

  // zero only qualifies pc_write_cond inside the datapath
  logic unused_zero;
  assign unused_zero = zero;

  assign rdy = mem_ready | ~MEM_WAIT_EN_DEFAULT;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:     if (rdy) state_d = S_DECODE;
      S_DECODE:    state_d = decode_op(opcode);
      S_MEM_ADDR:  state_d = (opcode_q == OP_SW) ?
                             S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (rdy) state_d = S_MEM_WB;
      S_MEM_WRITE: if (rdy) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_TRAP:      state_d = S_TRAP;
      S_MEM_WB,
      S_R_WB,
      S_BRANCH,
      S_JUMP,
      S_ADDI_WB:   state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

`ifdef PERF_COUNTERS_EN
  logic [31:0] cyc_q, ret_q;
  logic        retire;
  assign retire = (state_q != S_FETCH) &&
                  (state_d == S_FETCH);
  assign cycle_count   = cyc_q;
  assign retired_count = ret_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
`ifdef PERF_COUNTERS_EN
      cyc_q     <= '0;
      ret_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) opcode_q <= opcode;
      if (state_d == S_TRAP) illegal_q <= 1'b1;
`ifdef PERF_COUNTERS_EN
      cyc_q <= cyc_q + 32'd1;
      if (retire) ret_q <= ret_q + 32'd1;
`endif
    end
  end

  // reset kills every enable in the cycle it is asserted
  ctrl_output_decode u_dec (
    .state_i   (state_q),
    .mem_rdy_i (rdy),
    .kill_i    (reset),
    .ctrl_o    (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign illegal       = illegal_q;
  assign state_out     = state_q;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Moore-style control unit that sequences the PC/instruction-memory datapath as a multicycle MIPS-subset processor.
- Phases: fetch, decode, execute, memory, writeback.
- Drives every datapath enable and mux select from its state register and the latched opcode.
- Stalls on a single-bit memory-ready handshake.
- Sits beside the datapath; the top level wires opcode/zero in and control lines out.

Parameters:
- MEM_WAIT_EN_DEFAULT, 1, 1 = honour mem_ready; 0 = treat memory as always ready.
- OPCODE_W, 6, opcode field width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  instr[31:26] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero (beq).
- i_or_d  out  1  memory address select, 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  writeback source, 1 = MDR.
- reg_dst  out  1  destination select, 1 = rd.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A select, 1 = register A.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted immediate.
- alu_op  out  2  ALU op class: 00 = add, 01 = sub, 10 = funct, 11 = add-immediate.
- pc_source  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- illegal  out  1  sticky: unsupported opcode decoded.
- state_out  out  4  current state encoding, for debug.

Behaviour:
- The reset port is `reset` on clock `clk`; reset is synchronous and active-high.
- While reset is high at a clock edge:
  - state <= FETCH; illegal <= 0.
  - All write/read enables are forced to 0 in the same cycle.
- Reset mid-operation abandons the instruction; no partial writes follow.
- State encodings:
  - 0 FETCH, 1 DECODE, 2 MEM_ADDR, 3 MEM_READ, 4 MEM_WB, 5 MEM_WRITE.
  - 6 R_EXEC, 7 R_WB, 8 BRANCH, 9 JUMP, 10 ADDI_EXEC, 11 ADDI_WB, 12 TRAP.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write = mem_ready.
  - Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
  - Next state by opcode:
    - 000000 -> R_EXEC.
    - 100011 / 101011 -> MEM_ADDR.
    - 000100 -> BRANCH.
    - 000010 -> JUMP.
    - 001000 -> ADDI_EXEC.
    - Any other opcode -> TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEM_READ for lw, MEM_WRITE for sw; the opcode is latched in DECODE.
- MEM_READ: mem_read=1, i_or_d=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next state FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Hold until mem_ready, then go to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next state R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Next state FETCH.
- JUMP: pc_write=1, pc_source=10. Next state FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=11. Next state ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0. Next state FETCH.
- TRAP:
  - illegal <= 1; all enables 0.
  - Stays in TRAP until reset.
- Outputs not listed for a state are 0.
- The opcode is sampled into an internal register on DECODE only; later opcode changes are ignored.
- Latency in cycles with mem_ready always 1: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
- Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds exactly 1 cycle.
- mem_read and mem_write are never both 1.

Optional Feature:
- Macro PERF_COUNTERS_EN.
- When defined, the block adds:
  - Outputs cycle_count[31:0] and retired_count[31:0].
  - cycle_count increments every non-reset cycle.
  - retired_count increments on each transition into FETCH from a completing state.
  - Both counters clear on reset and wrap modulo 2^32.
- When undefined, the ports and logic are absent.

Decomposition:
- Shared package ctrl_pkg holds:
  - state enum (4-bit).
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI.
  - alu_op, alu_src_b and pc_source encodings.
- One natural sub-module: ctrl_output_decode, a combinational mapping of state (plus mem_ready) to control lines.
- The state register and next-state logic stay in the top module.

Test Plan:
- Reset held 2 cycles, then released, opcode=000000, mem_ready=1 -> states 0,1,6,7,0. reg_write=1 only in the state-7 cycle with reg_dst=1.
- lw (100011) with mem_ready low 2 cycles in MEM_READ -> states 0,1,2,3,3,3,4,0. mem_read=1 and i_or_d=1 throughout state 3.
- beq (000100) -> BRANCH cycle shows pc_write_cond=1, alu_op=01, pc_source=01. Back to FETCH on the next cycle.
- Opcode 111111 in DECODE -> TRAP. illegal=1 is held for 10 cycles with all enables 0. Reset returns to FETCH with illegal=0.
- Reset asserted during MEM_WRITE with mem_ready=0 -> next cycle is FETCH. mem_write is never asserted after the reset edge.
- PERF_COUNTERS_EN: j then addi after reset with mem_ready=1 -> retired_count=2 and cycle_count=7 at the second return to FETCH.
